mem_entry_ctrl: RTL and testbench

Operator-entry controller sitting between the debounced board buttons/switches and the SingleCPU data-memory write port. It turns Next/Pre/Verify button levels into single-cycle events, keeps the current entry index and byte address, and commits the 12-bit switch value to CPU memory through a req/ack handshake with timeout. It also tracks which entries have been written. It supplies the address and index shown on the seven-segment display.

---
 rtl/mem_entry_pkg.sv | 24 ++
 rtl/edge_pulse.sv | 24 ++
 rtl/mem_entry_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_entry_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_entry_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_entry_pkg
//  Description : Shared types and constants for the operator-entry controller.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_entry_pkg;

    localparam int DATA_W      = 12;
    localparam int WORD_W      = 32;
    localparam int IDX_W       = 4;
    localparam int VALID_W     = 16;

    localparam int DEF_DEPTH   = 16;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        ERR      = 2'd2
    } state_t;

endpackage : mem_entry_pkg
`default_nettype wire

// File: rtl/edge_pulse.sv
`default_nettype none
// ============================================================================
//  Module      : edge_pulse
//  Description : Rising-edge detector turning a button level into a 1-cycle event.
//  Revision    : 1.0  initial release
// ============================================================================
module edge_pulse (
    input  logic clk,
    input  logic i_level,
    output logic o_pulse
);

    logic r_level_q;

    // History tracks the level even while reset is asserted, so a button
    // held through reset is seen as already high and fires no event.
    always_ff @(posedge clk) begin
        r_level_q <= i_level;
    end

    assign o_pulse = i_level & ~r_level_q;

endmodule : edge_pulse
`default_nettype wire

// File: rtl/mem_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_entry_ctrl
//  Description : Button-driven entry index plus req/ack commit of switch values
//                into CPU data memory, with timeout and per-entry written flags.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_entry_ctrl
    import mem_entry_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Next,
    input  logic                Pre,
    input  logic                Verify,
    input  logic                Stop,
    input  logic [DATA_W-1:0]   Number,
    output logic                WrReq,
    output logic [WORD_W-1:0]   WrAddr,
    output logic [WORD_W-1:0]   WrData,
    input  logic                WrAck,
    output logic [WORD_W-1:0]   Address,
    output logic [IDX_W-1:0]    Count,
    output logic [VALID_W-1:0]  Valid,
    output logic                AllValid,
    output logic                Busy,
    output logic                Error
);

    localparam int                 c_TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]   c_IDX_MASK = IDX_W'(DEPTH - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    logic w_ev_next;
    logic w_ev_pre;
    logic w_ev_verify;

    edge_pulse u_next_pulse (
        .clk     (CLK),
        .i_level (Next),
        .o_pulse (w_ev_next)
    );

    edge_pulse u_pre_pulse (
        .clk     (CLK),
        .i_level (Pre),
        .o_pulse (w_ev_pre)
    );

    edge_pulse u_verify_pulse (
        .clk     (CLK),
        .i_level (Verify),
        .o_pulse (w_ev_verify)
    );

    state_t              r_state;
    logic [IDX_W-1:0]    r_count;
    logic [VALID_W-1:0]  r_valid;
    logic [c_TMO_W-1:0]  r_tmo;
    logic                r_error;
    logic [WORD_W-1:0]   r_wraddr;
    logic [DATA_W-1:0]   r_wrdata;

    state_t              w_state_nxt;
    logic [IDX_W-1:0]    w_count_nxt;
    logic [VALID_W-1:0]  w_valid_nxt;
    logic [c_TMO_W-1:0]  w_tmo_nxt;
    logic                w_error_nxt;
    logic [WORD_W-1:0]   w_wraddr_nxt;
    logic [DATA_W-1:0]   w_wrdata_nxt;

    logic [WORD_W-1:0]   w_address;
    logic [IDX_W-1:0]    w_count_inc;
    logic [IDX_W-1:0]    w_count_dec;

    assign w_address   = {{(WORD_W-IDX_W-2){1'b0}}, r_count, 2'b00};
    assign w_count_inc = (r_count + IDX_W'(1)) & c_IDX_MASK;
    assign w_count_dec = (r_count - IDX_W'(1)) & c_IDX_MASK;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_valid  <= '0;
            r_tmo    <= '0;
            r_error  <= 1'b0;
            r_wraddr <= '0;
            r_wrdata <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_valid  <= w_valid_nxt;
            r_tmo    <= w_tmo_nxt;
            r_error  <= w_error_nxt;
            r_wraddr <= w_wraddr_nxt;
            r_wrdata <= w_wrdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_valid_nxt  = r_valid;
        w_tmo_nxt    = r_tmo;
        w_error_nxt  = r_error;
        w_wraddr_nxt = r_wraddr;
        w_wrdata_nxt = r_wrdata;

        case (r_state)
            IDLE: begin
                // An accepted Verify swallows any Next/Pre event of the same cycle.
                if (w_ev_verify && !Stop) begin
                    w_wraddr_nxt = w_address;
                    w_wrdata_nxt = Number;
                    w_tmo_nxt    = '0;
                    w_state_nxt  = WAIT_ACK;
                end else if (w_ev_next && !w_ev_pre) begin
                    w_count_nxt = w_count_inc;
                end else if (w_ev_pre && !w_ev_next) begin
                    w_count_nxt = w_count_dec;
                end
            end
            WAIT_ACK: begin
                if (WrAck) begin
                    w_valid_nxt = r_valid | (VALID_W'(1) << r_count);
                    w_count_nxt = w_count_inc;
                    w_state_nxt = IDLE;
                end else if (r_tmo == c_TMO_LAST) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = ERR;
                end else begin
                    w_tmo_nxt = r_tmo + c_TMO_W'(1);
                end
            end
            ERR: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign WrReq    = (r_state == WAIT_ACK);
    assign Busy     = (r_state == WAIT_ACK);
    assign WrAddr   = r_wraddr;
    assign WrData   = {{(WORD_W-DATA_W){1'b0}}, r_wrdata};
    assign Address  = w_address;
    assign Count    = r_count;
    assign Valid    = r_valid;
    assign AllValid = &r_valid[DEPTH-1:0];
    assign Error    = r_error;

endmodule : mem_entry_ctrl
`default_nettype wire

// File: tb/tb_mem_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_entry_ctrl
//  Description : Self-checking bench for mem_entry_ctrl with a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_entry_ctrl;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 255;

    logic        CLK    = 1'b0;
    logic        Reset  = 1'b1;
    logic        Next   = 1'b0;
    logic        Pre    = 1'b0;
    logic        Verify = 1'b0;
    logic        Stop   = 1'b0;
    logic        WrAck  = 1'b0;
    logic [11:0] Number = 12'h0;

    logic        WrReq;
    logic [31:0] WrAddr;
    logic [31:0] WrData;
    logic [31:0] Address;
    logic [3:0]  Count;
    logic [15:0] Valid;
    logic        AllValid;
    logic        Busy;
    logic        Error;

    mem_entry_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Next     (Next),
        .Pre      (Pre),
        .Verify   (Verify),
        .Stop     (Stop),
        .Number   (Number),
        .WrReq    (WrReq),
        .WrAddr   (WrAddr),
        .WrData   (WrData),
        .WrAck    (WrAck),
        .Address  (Address),
        .Count    (Count),
        .Valid    (Valid),
        .AllValid (AllValid),
        .Busy     (Busy),
        .Error    (Error)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an entry index, a set of written entries, and
    // a pending write that either gets acknowledged or runs out of cycles.
    int          m_count   = 0;
    bit [15:0]   m_valid   = '0;
    bit          m_pending = 1'b0;
    int          m_waited  = 0;
    bit          m_cooloff = 1'b0;
    bit          m_error   = 1'b0;
    logic [31:0] m_addr    = '0;
    logic [31:0] m_data    = '0;
    bit          m_prev_n  = 1'b0;
    bit          m_prev_p  = 1'b0;
    bit          m_prev_v  = 1'b0;
    bit          m_live    = 1'b0;

    always @(posedge CLK) begin
        bit ev_n, ev_p, ev_v;
        ev_n = Next   && !m_prev_n;
        ev_p = Pre    && !m_prev_p;
        ev_v = Verify && !m_prev_v;
        if (Reset) begin
            m_count = 0; m_valid = '0; m_pending = 0; m_waited = 0;
            m_cooloff = 0; m_error = 0; m_addr = '0; m_data = '0;
            m_live = 1'b1;
        end else if (m_cooloff) begin
            m_cooloff = 0;
        end else if (m_pending) begin
            if (WrAck) begin
                m_valid[m_count] = 1'b1;
                m_count   = (m_count + 1) % DEPTH;
                m_pending = 0;
            end else begin
                m_waited++;
                if (m_waited == TIMEOUT) begin
                    m_pending = 0;
                    m_error   = 1;
                    m_cooloff = 1;
                end
            end
        end else if (ev_v && !Stop) begin
            m_pending = 1;
            m_waited  = 0;
            m_addr    = m_count * 4;
            m_data    = {20'h0, Number};
        end else if (ev_n && !ev_p) begin
            m_count = (m_count + 1) % DEPTH;
        end else if (ev_p && !ev_n) begin
            m_count = (m_count + DEPTH - 1) % DEPTH;
        end
        m_prev_n = Next;
        m_prev_p = Pre;
        m_prev_v = Verify;
    end

    always @(negedge CLK) begin
        if (m_live) begin
            check("WrReq",    32'(WrReq),    32'(m_pending));
            check("Busy",     32'(Busy),     32'(m_pending));
            check("Count",    32'(Count),    32'(m_count));
            check("Address",  Address,       32'(m_count * 4));
            check("Valid",    32'(Valid),    32'(m_valid));
            check("AllValid", 32'(AllValid), 32'(m_valid == 16'hFFFF));
            check("Error",    32'(Error),    32'(m_error));
            check("WrAddr",   WrAddr,        m_addr);
            check("WrData",   WrData,        m_data);
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic press(input bit n, input bit p, input bit v);
        Next = n; Pre = p; Verify = v;
        tick();
        Next = 0; Pre = 0; Verify = 0;
        tick();
    endtask

    task automatic commit(input logic [11:0] val);
        Number = val; Verify = 1;
        tick();
        Verify = 0; WrAck = 1;
        tick();
        WrAck = 0;
    endtask

    int n;

    initial begin
        // Reset with Next held through it
        Next = 1;
        repeat (3) tick();
        check("rst_count", 32'(Count), 32'd0);
        check("rst_wrreq", 32'(WrReq), 32'd0);
        check("rst_valid", 32'(Valid), 32'd0);
        check("rst_wraddr", WrAddr, 32'd0);
        Reset = 0;
        repeat (2) tick();
        check("held_through_reset", 32'(Count), 32'd0);
        Next = 0;
        tick();

        repeat (3) press(1, 0, 0);
        press(0, 1, 0);
        check("nav_count", 32'(Count), 32'd2);
        check("nav_addr", Address, 32'h8);

        // Commit with WrAck three cycles after the request
        Stop = 0; Number = 12'hABC; Verify = 1;
        tick();
        Verify = 0;
        for (int i = 0; i < 3; i++) begin
            check("hold_wrreq", 32'(WrReq), 32'd1);
            check("hold_wraddr", WrAddr, 32'h8);
            check("hold_wrdata", WrData, 32'h00000ABC);
            if (i == 2) WrAck = 1;
            tick();
        end
        WrAck = 0;
        check("commit_valid2", 32'(Valid[2]), 32'd1);
        check("commit_count", 32'(Count), 32'd3);
        check("commit_wrreq", 32'(WrReq), 32'd0);

        // Wrap on auto-advance, then Pre wrap
        repeat (12) press(1, 0, 0);
        check("count15", 32'(Count), 32'd15);
        Number = 12'h5A5; Verify = 1; WrAck = 1;
        tick();
        Verify = 0;
        tick();
        WrAck = 0;
        check("wrap_count", 32'(Count), 32'd0);
        check("wrap_valid15", 32'(Valid[15]), 32'd1);
        press(0, 1, 0);
        check("pre_wrap", 32'(Count), 32'd15);
        press(1, 0, 0);

        // Timeout
        Number = 12'h123; Verify = 1;
        tick();
        Verify = 0;
        n = 0;
        while (WrReq === 1'b1 && n < 1000) begin
            n++;
            tick();
        end
        check("timeout_len", 32'(n), 32'd255);
        check("timeout_err", 32'(Error), 32'd1);
        check("timeout_valid", 32'(Valid), 32'h8004);
        tick();
        commit(12'h321);
        check("after_err_valid", 32'(Valid), 32'h8005);
        check("after_err_count", 32'(Count), 32'd1);

        // Simultaneous events and view mode
        press(1, 1, 0);
        check("next_pre_same", 32'(Count), 32'd1);
        Next = 1; Verify = 1; Number = 12'h777;
        tick();
        Next = 0; Verify = 0;
        check("verify_wins_addr", WrAddr, 32'h4);
        Next = 1;
        tick();
        Next = 0;
        tick();
        WrAck = 1;
        tick();
        WrAck = 0;
        check("wait_next_ignored", 32'(Count), 32'd2);
        Stop = 1; Verify = 1;
        tick();
        Verify = 0;
        check("stop_no_req", 32'(WrReq), 32'd0);
        tick();
        Stop = 0;

        // Fill every entry, then reset mid-write
        for (int i = 0; i < DEPTH; i++) commit(12'($urandom));
        check("allvalid", 32'(AllValid), 32'd1);
        Verify = 1;
        tick();
        Verify = 0;
        check("pre_reset_req", 32'(WrReq), 32'd1);
        Reset = 1;
        tick();
        check("reset_wait_req", 32'(WrReq), 32'd0);
        check("reset_wait_valid", 32'(Valid), 32'd0);
        check("reset_wait_count", 32'(Count), 32'd0);
        Reset = 0;
        tick();

        // Randomized phases: frequent acks, then rare acks to hit timeouts
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 2500; c++) begin
                Next   = ($urandom_range(0, 5) == 0);
                Pre    = ($urandom_range(0, 7) == 0);
                Verify = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 40) == 0) Stop = ~Stop;
                Number = 12'($urandom);
                WrAck  = (ph == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 299) == 0);
                Reset  = ($urandom_range(0, 799) == 0);
                tick();
            end
        end
        Reset = 0; Next = 0; Pre = 0; Verify = 0; WrAck = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_entry_ctrl
`default_nettype wire
